// File: rtl/axi4l_cmd_master.sv
// AXI4-Lite master command engine: buffers read/write commands in a FIFO, issues
// them one at a time on the ca4l_* bus and returns one response word per command.
module axi4l_cmd_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                fclk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_we,
    output logic [DATA_W-1:0]   rsp_data,
    output logic [1:0]          rsp_resp,
    output logic                rsp_timeout,
    output logic                busy,
    output logic [ADDR_W-1:0]   ca4l_araddr,
    output logic [2:0]          ca4l_arprot,
    output logic                ca4l_arvalid,
    input  logic                ca4l_arready,
    output logic [ADDR_W-1:0]   ca4l_awaddr,
    output logic [2:0]          ca4l_awprot,
    output logic                ca4l_awvalid,
    input  logic                ca4l_awready,
    output logic [DATA_W-1:0]   ca4l_wdata,
    output logic [DATA_W/8-1:0] ca4l_wstrb,
    output logic                ca4l_wvalid,
    input  logic                ca4l_wready,
    input  logic                ca4l_bvalid,
    input  logic [1:0]          ca4l_bresp,
    output logic                ca4l_bready,
    input  logic                ca4l_rvalid,
    input  logic [1:0]          ca4l_rresp,
    input  logic [DATA_W-1:0]   ca4l_rdata,
    output logic                ca4l_rready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CMD_W  = 1 + ADDR_W + DATA_W + STRB_W;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;

    state_t state, state_nx;

    logic [CMD_W-1:0]  fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count, count_nx;
    logic              push, pop;
    logic              head_we;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;
    logic [STRB_W-1:0] head_strb;

    logic [CNT_W-1:0]  tcnt;
    logic              to_hit, abort;
    logic              aw_hs, w_hs, ar_hs, b_hs, r_hs, aw_done, w_done;

    logic              arvalid_d, awvalid_d, wvalid_d, bready_d, rready_d;
    logic [ADDR_W-1:0] araddr_d, awaddr_d;
    logic [DATA_W-1:0] wdata_d, rsp_data_d;
    logic [STRB_W-1:0] wstrb_d;
    logic              rsp_we_d, rsp_timeout_d;
    logic [1:0]        rsp_resp_d;

    assign ca4l_arprot = 3'b000;
    assign ca4l_awprot = 3'b000;

    assign push = cmd_valid & cmd_ready;
    assign pop  = (state == IDLE) && (count != '0);
    assign {head_we, head_addr, head_wdata, head_strb} = fifo_mem[rd_ptr];

    always_comb begin
        count_nx = count;
        if (push && !pop)
            count_nx = count + 1'b1;
        else if (pop && !push)
            count_nx = count - 1'b1;
    end

    always_ff @(posedge fclk) begin
        if (push && !rst)
            fifo_mem[wr_ptr] <= {cmd_we, cmd_addr, cmd_wdata, cmd_wstrb};
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cmd_ready <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count     <= count_nx;
            cmd_ready <= (count_nx != (PTR_W + 1)'(DEPTH));
        end
    end

    assign aw_hs   = ca4l_awvalid & ca4l_awready;
    assign w_hs    = ca4l_wvalid & ca4l_wready;
    assign ar_hs   = ca4l_arvalid & ca4l_arready;
    assign b_hs    = ca4l_bready & ca4l_bvalid;
    assign r_hs    = ca4l_rready & ca4l_rvalid;
    // A channel counts as done once its valid has dropped or is handshaking now.
    assign aw_done = !ca4l_awvalid || ca4l_awready;
    assign w_done  = !ca4l_wvalid || ca4l_wready;
    assign to_hit  = (TIMEOUT != 0) && (tcnt == TO_LAST);

    always_ff @(posedge fclk) begin
        if (rst) begin
            state <= IDLE;
            tcnt  <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state)
                tcnt <= '0;
            else if (state != IDLE && state != RSP)
                tcnt <= tcnt + 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pop) state_nx = head_we ? WR_AW_W : RD_AR;
            WR_AW_W: if (aw_done && w_done) state_nx = WR_B;
                     else if (to_hit) state_nx = RSP;
            WR_B:    if (b_hs || to_hit) state_nx = RSP;
            RD_AR:   if (ar_hs) state_nx = RD_R;
                     else if (to_hit) state_nx = RSP;
            RD_R:    if (r_hs || to_hit) state_nx = RSP;
            RSP:     if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        arvalid_d     = ca4l_arvalid;
        awvalid_d     = ca4l_awvalid;
        wvalid_d      = ca4l_wvalid;
        bready_d      = ca4l_bready;
        rready_d      = ca4l_rready;
        araddr_d      = ca4l_araddr;
        awaddr_d      = ca4l_awaddr;
        wdata_d       = ca4l_wdata;
        wstrb_d       = ca4l_wstrb;
        rsp_we_d      = rsp_we;
        rsp_data_d    = rsp_data;
        rsp_resp_d    = rsp_resp;
        rsp_timeout_d = rsp_timeout;
        abort         = 1'b0;
        case (state)
            IDLE: if (pop) begin
                rsp_we_d = head_we;
                if (head_we) begin
                    awaddr_d  = head_addr;
                    wdata_d   = head_wdata;
                    wstrb_d   = head_strb;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end else begin
                    araddr_d  = head_addr;
                    arvalid_d = 1'b1;
                end
            end
            WR_AW_W: begin
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                if (aw_done && w_done) bready_d = 1'b1;
                else if (to_hit)       abort    = 1'b1;
            end
            WR_B: if (b_hs) begin
                bready_d      = 1'b0;
                rsp_data_d    = '0;
                rsp_resp_d    = ca4l_bresp;
                rsp_timeout_d = 1'b0;
            end else if (to_hit) abort = 1'b1;
            RD_AR: if (ar_hs) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
            end else if (to_hit) abort = 1'b1;
            RD_R: if (r_hs) begin
                rready_d      = 1'b0;
                rsp_data_d    = ca4l_rdata;
                rsp_resp_d    = ca4l_rresp;
                rsp_timeout_d = 1'b0;
            end else if (to_hit) abort = 1'b1;
            default: ;
        endcase
        // Recovery abort drops every handshake line at once, even mid-transfer.
        if (abort) begin
            arvalid_d     = 1'b0;
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            rready_d      = 1'b0;
            rsp_data_d    = '0;
            rsp_resp_d    = 2'b10;
            rsp_timeout_d = 1'b1;
        end
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            ca4l_arvalid <= 1'b0;
            ca4l_awvalid <= 1'b0;
            ca4l_wvalid  <= 1'b0;
            ca4l_bready  <= 1'b0;
            ca4l_rready  <= 1'b0;
            ca4l_araddr  <= '0;
            ca4l_awaddr  <= '0;
            ca4l_wdata   <= '0;
            ca4l_wstrb   <= '0;
            rsp_valid    <= 1'b0;
            rsp_we       <= 1'b0;
            rsp_data     <= '0;
            rsp_resp     <= '0;
            rsp_timeout  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            ca4l_arvalid <= arvalid_d;
            ca4l_awvalid <= awvalid_d;
            ca4l_wvalid  <= wvalid_d;
            ca4l_bready  <= bready_d;
            ca4l_rready  <= rready_d;
            ca4l_araddr  <= araddr_d;
            ca4l_awaddr  <= awaddr_d;
            ca4l_wdata   <= wdata_d;
            ca4l_wstrb   <= wstrb_d;
            rsp_valid    <= (state_nx == RSP);
            rsp_we       <= rsp_we_d;
            rsp_data     <= rsp_data_d;
            rsp_resp     <= rsp_resp_d;
            rsp_timeout  <= rsp_timeout_d;
            busy         <= (state_nx != IDLE) || (count_nx != '0);
        end
    end

endmodule

// File: tb/tb_axi4l_cmd_master.sv
// Scoreboard bench for axi4l_cmd_master against a small AXI4-Lite slave model
// with programmable AW/W skew, AR stall and B stall.
module tb_axi4l_cmd_master;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic        fclk, rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_we, rsp_timeout, busy;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic [31:0] ca4l_araddr, ca4l_awaddr, ca4l_wdata, ca4l_rdata;
    logic [2:0]  ca4l_arprot, ca4l_awprot;
    logic [3:0]  ca4l_wstrb;
    logic        ca4l_arvalid, ca4l_arready, ca4l_awvalid, ca4l_awready;
    logic        ca4l_wvalid, ca4l_wready, ca4l_bvalid, ca4l_bready;
    logic        ca4l_rvalid, ca4l_rready;
    logic [1:0]  ca4l_bresp, ca4l_rresp;

    axi4l_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .fclk(fclk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
        .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
        .ca4l_araddr(ca4l_araddr), .ca4l_arprot(ca4l_arprot), .ca4l_arvalid(ca4l_arvalid),
        .ca4l_arready(ca4l_arready),
        .ca4l_awaddr(ca4l_awaddr), .ca4l_awprot(ca4l_awprot), .ca4l_awvalid(ca4l_awvalid),
        .ca4l_awready(ca4l_awready),
        .ca4l_wdata(ca4l_wdata), .ca4l_wstrb(ca4l_wstrb), .ca4l_wvalid(ca4l_wvalid),
        .ca4l_wready(ca4l_wready),
        .ca4l_bvalid(ca4l_bvalid), .ca4l_bresp(ca4l_bresp), .ca4l_bready(ca4l_bready),
        .ca4l_rvalid(ca4l_rvalid), .ca4l_rresp(ca4l_rresp), .ca4l_rdata(ca4l_rdata),
        .ca4l_rready(ca4l_rready)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    typedef struct packed {
        logic        we;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        to;
    } exp_t;

    localparam exp_t WR_OK = '{we: 1'b1, data: 32'h0, resp: 2'b00, to: 1'b0};

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_acc = 0;
    int   cyc = 0;
    int   t_aw_fall, t_w_fall, t_b_rise, t_ar_rise, t_ar_fall;
    bit   bp_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave model: ready/valid decisions at negedge, taking effect at the next posedge.
    logic [31:0] mem [16];
    bit          cfg_ar_block, cfg_b_block;
    int          cfg_aw_delay, cfg_w_delay;
    int          aw_cnt, w_cnt;
    bit          s_have_aw, s_have_w, s_have_ar, b_armed, r_armed;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;

    always @(negedge fclk) begin
        if (rst) begin
            ca4l_awready = 0; ca4l_wready = 0; ca4l_arready = 0;
            ca4l_bvalid = 0; ca4l_rvalid = 0;
            ca4l_bresp = 2'b00; ca4l_rresp = 2'b00; ca4l_rdata = '0;
            s_have_aw = 0; s_have_w = 0; s_have_ar = 0;
            b_armed = 0; r_armed = 0; aw_cnt = 0; w_cnt = 0;
        end else begin
            if (ca4l_bvalid && b_armed) ca4l_bvalid = 0;
            if (ca4l_rvalid && r_armed) ca4l_rvalid = 0;
            if (s_have_aw && s_have_w && !ca4l_bvalid && !cfg_b_block) begin
                for (int b = 0; b < 4; b++)
                    if (s_wstrb[b]) mem[s_awaddr[5:2]][8*b +: 8] = s_wdata[8*b +: 8];
                ca4l_bvalid = 1; ca4l_bresp = 2'b00;
                s_have_aw = 0; s_have_w = 0;
            end
            if (s_have_ar && !ca4l_rvalid) begin
                ca4l_rvalid = 1; ca4l_rresp = 2'b00; ca4l_rdata = mem[s_araddr[5:2]];
                s_have_ar = 0;
            end
            ca4l_awready = 0;
            if (ca4l_awvalid && !s_have_aw) begin
                if (aw_cnt >= cfg_aw_delay) begin
                    ca4l_awready = 1; s_have_aw = 1; s_awaddr = ca4l_awaddr; aw_cnt = 0;
                end else aw_cnt++;
            end
            ca4l_wready = 0;
            if (ca4l_wvalid && !s_have_w) begin
                if (w_cnt >= cfg_w_delay) begin
                    ca4l_wready = 1; s_have_w = 1; s_wdata = ca4l_wdata; s_wstrb = ca4l_wstrb; w_cnt = 0;
                end else w_cnt++;
            end
            ca4l_arready = 0;
            if (ca4l_arvalid && !s_have_ar && !cfg_ar_block) begin
                ca4l_arready = 1; s_have_ar = 1; s_araddr = ca4l_araddr;
            end
            b_armed = ca4l_bvalid && ca4l_bready;
            r_armed = ca4l_rvalid && ca4l_rready;
        end
    end

    // Monitor: edge timestamps and scoreboard pop on every response handshake.
    logic prev_aw = 0, prev_w = 0, prev_b = 0, prev_ar = 0;
    always @(negedge fclk) begin
        exp_t e;
        #1;
        cyc++;
        if (!rst) begin
            if (ca4l_awvalid && !prev_aw) chk("aw_w_rise_together", 64'(ca4l_wvalid), 64'd1);
            if (!ca4l_awvalid && prev_aw) t_aw_fall = cyc;
            if (!ca4l_wvalid && prev_w)   t_w_fall  = cyc;
            if (ca4l_bready && !prev_b)   t_b_rise  = cyc;
            if (ca4l_arvalid && !prev_ar) t_ar_rise = cyc;
            if (!ca4l_arvalid && prev_ar) t_ar_fall = cyc;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_rsp: got data 0x%0h with no response expected", rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_we", 64'(rsp_we), 64'(e.we));
                    chk("rsp_data", 64'(rsp_data), 64'(e.data));
                    chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
                    chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
                end
            end
        end
        prev_aw = ca4l_awvalid; prev_w = ca4l_wvalid;
        prev_b  = ca4l_bready;  prev_ar = ca4l_arvalid;
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_cmd(input logic we, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input exp_t e);
        int t = 0;
        cmd_we = we; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1;
        while (!cmd_ready && t < 200) begin
            @(negedge fclk);
            t++;
        end
        if (!cmd_ready) begin
            n_cmp++; n_err++;
            $display("FAIL push_wait: cmd_ready still 0 after %0d cycles, required 1", t);
        end else begin
            exp_q.push_back(e);
            n_acc++;
        end
        @(negedge fclk);
        cmd_valid = 0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 500) begin
            @(negedge fclk);
            t++;
        end
        if (t >= 500) begin
            n_cmp++; n_err++;
            $display("FAIL %s_drain: %0d responses outstanding, busy=%0b, required 0/0", name, exp_q.size(), busy);
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int t;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        rst = 1; cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1; cfg_ar_block = 0; cfg_b_block = 0; cfg_aw_delay = 0; cfg_w_delay = 0;
        repeat (3) @(negedge fclk);
        rst = 0;
        @(negedge fclk);
        chk("reset_axi_ctrl", 64'({ca4l_arvalid, ca4l_awvalid, ca4l_wvalid, ca4l_bready, ca4l_rready}), 64'd0);
        chk("reset_addr", {ca4l_araddr, ca4l_awaddr}, 64'd0);
        chk("reset_wdata", {ca4l_wdata, 28'd0, ca4l_wstrb}, 64'd0);
        chk("reset_rsp", {rsp_data, 27'd0, rsp_valid, rsp_we, rsp_resp, rsp_timeout}, 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);

        // Write then read, zero-wait slave
        push_cmd(1, 32'h0, 32'h2, 4'hF, WR_OK);
        push_cmd(0, 32'h0, 32'h0, 4'h0, '{we: 1'b0, data: 32'h2, resp: 2'b00, to: 1'b0});
        wait_idle("wr_rd");

        // AW/W skew: W first, then AW first
        cfg_aw_delay = 3; cfg_w_delay = 0;
        push_cmd(1, 32'h4, 32'h11, 4'hF, WR_OK);
        wait_idle("skew1");
        chk("skew1_w_leads_aw", 64'(t_aw_fall - t_w_fall), 64'd3);
        chk("skew1_bready_after_both", 64'(t_b_rise - t_aw_fall), 64'd0);
        cfg_aw_delay = 0; cfg_w_delay = 3;
        push_cmd(1, 32'h4, 32'h11, 4'hF, WR_OK);
        wait_idle("skew2");
        chk("skew2_aw_leads_w", 64'(t_w_fall - t_aw_fall), 64'd3);
        chk("skew2_bready_after_both", 64'(t_b_rise - t_w_fall), 64'd0);
        cfg_w_delay = 0;
        push_cmd(0, 32'h4, 32'h0, 4'h0, '{we: 1'b0, data: 32'h11, resp: 2'b00, to: 1'b0});
        wait_idle("skew_rd");

        // Backpressure: DEPTH+2 commands with rsp_ready held low
        rsp_ready = 0; n_acc = 0; bp_done = 0;
        fork
            begin
                push_cmd(0, 32'h0,  32'h0,  4'h0, '{we: 1'b0, data: 32'h2,  resp: 2'b00, to: 1'b0});
                push_cmd(1, 32'h10, 32'hA1, 4'hF, WR_OK);
                push_cmd(1, 32'h14, 32'hA2, 4'hF, WR_OK);
                push_cmd(0, 32'h10, 32'h0,  4'h0, '{we: 1'b0, data: 32'hA1, resp: 2'b00, to: 1'b0});
                push_cmd(0, 32'h14, 32'h0,  4'h0, '{we: 1'b0, data: 32'hA2, resp: 2'b00, to: 1'b0});
                push_cmd(0, 32'h4,  32'h0,  4'h0, '{we: 1'b0, data: 32'h11, resp: 2'b00, to: 1'b0});
                bp_done = 1;
            end
        join_none
        repeat (30) @(negedge fclk);
        chk("bp_accepted_until_full", 64'(n_acc), 64'(DEPTH + 1));
        chk("bp_cmd_ready_low", 64'(cmd_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("bp_first_rsp_held", {31'd0, rsp_valid, rsp_we, rsp_data}, {31'd0, 1'b1, 1'b0, 32'h2});
            @(negedge fclk);
        end
        rsp_ready = 1;
        t = 0;
        while (!bp_done && t < 300) begin
            @(negedge fclk);
            t++;
        end
        chk("bp_all_pushed", 64'(bp_done), 64'd1);
        wait_idle("bp");

        // Timeout on a stalled AR, then a queued write completes normally
        cfg_ar_block = 1;
        push_cmd(0, 32'h20, 32'h0, 4'h0, '{we: 1'b0, data: 32'h0, resp: 2'b10, to: 1'b1});
        push_cmd(1, 32'h8, 32'hC38D, 4'hF, WR_OK);
        wait_idle("timeout");
        chk("to_arvalid_width", 64'(t_ar_fall - t_ar_rise), 64'(TIMEOUT));
        cfg_ar_block = 0;
        push_cmd(0, 32'h8, 32'h0, 4'h0, '{we: 1'b0, data: 32'hC38D, resp: 2'b00, to: 1'b0});
        wait_idle("to_rd");

        // Reset while in WR_B with two commands queued
        cfg_b_block = 1;
        push_cmd(1, 32'h30, 32'h5, 4'hF, WR_OK);
        push_cmd(0, 32'h0, 32'h0, 4'h0, WR_OK);
        push_cmd(0, 32'h4, 32'h0, 4'h0, WR_OK);
        t = 0;
        while (!ca4l_bready && t < 50) begin
            @(negedge fclk);
            t++;
        end
        chk("rst_reached_wr_b", 64'(ca4l_bready), 64'd1);
        rst = 1;
        @(negedge fclk);
        chk("rst_axi_ctrl", 64'({ca4l_arvalid, ca4l_awvalid, ca4l_wvalid, ca4l_bready, ca4l_rready}), 64'd0);
        chk("rst_axi_addr", {ca4l_araddr, ca4l_awaddr}, 64'd0);
        chk("rst_busy_rsp", 64'({busy, rsp_valid}), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        exp_q.delete();
        rst = 0; cfg_b_block = 0;
        repeat (10) @(negedge fclk);
        chk("rst_fifo_flushed", 64'({busy, rsp_valid}), 64'd0);

        push_cmd(1, 32'h30, 32'h7, 4'hF, WR_OK);
        push_cmd(0, 32'h30, 32'h0, 4'h0, '{we: 1'b0, data: 32'h7, resp: 2'b00, to: 1'b0});
        wait_idle("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
